// File: rtl/pipe_elastic_buf.sv
// Elastic in-order queue between two pipeline stages with valid/ready handshakes,
// whole-buffer flush for squash, and a saturating back-pressure counter.
module pipe_elastic_buf #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [OCC_W-1:0] count_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic             in_ready_s;
  logic             out_valid_s;
  logic [WIDTH-1:0] out_data_s;
  logic             push_s;
  logic             pop_s;
  logic             stall_s;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  // Handshake decode; in_ready is independent of out_ready so there is no
  // combinational path from the consumer back to the producer.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    out_data_s  = {WIDTH{1'b0}};
    push_s      = 1'b0;
    pop_s       = 1'b0;
    stall_s     = 1'b0;
    in_ready_s  = (count_r != OCC_FULL) && !flush;
    out_valid_s = (count_r != {OCC_W{1'b0}});
    if (out_valid_s) begin
      out_data_s = mem_r[rd_ptr_r];
    end else begin
      out_data_s = {WIDTH{1'b0}};
    end
    push_s  = in_valid && in_ready_s;
    pop_s   = out_valid_s && out_ready && !flush;
    stall_s = in_valid && !in_ready_s;
  end

  // Payload storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pointer and occupancy state; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {OCC_W{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {OCC_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + OCC_W'(1);
        2'b01:   count_r <= count_r - OCC_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Back-pressure counter survives flush and sticks at its maximum.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_data  = out_data_s;
  assign count     = count_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_elastic_buf.sv
// Directed bench for pipe_elastic_buf: three instances (DEPTH=2, DEPTH=3,
// and a 3-bit stall counter) driven by hand-computed vectors.
module tb_pipe_elastic_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Instance A: DEPTH=2, 32-bit stall counter
  logic       a_reset, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_count;
  logic [31:0] a_stall;

  // Instance B: DEPTH=3
  logic       b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_count;
  logic [7:0] b_stall;

  // Instance C: DEPTH=2, 3-bit stall counter
  logic       c_reset, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
  logic [7:0] c_in_data, c_out_data;
  logic [1:0] c_count;
  logic [2:0] c_stall;

  pipe_elastic_buf #(.WIDTH(8), .DEPTH(2), .CNT_W(32)) dut_a (
    .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .flush(a_flush), .count(a_count), .stall_cnt(a_stall)
  );

  pipe_elastic_buf #(.WIDTH(8), .DEPTH(3), .CNT_W(8)) dut_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .flush(b_flush), .count(b_count), .stall_cnt(b_stall)
  );

  pipe_elastic_buf #(.WIDTH(8), .DEPTH(2), .CNT_W(3)) dut_c (
    .clk(clk), .reset(c_reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .flush(c_flush), .count(c_count), .stall_cnt(c_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_reset = 1'b1; a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0; a_flush = 1'b0;
    b_reset = 1'b1; b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b0; b_flush = 1'b0;
    c_reset = 1'b1; c_in_valid = 1'b0; c_in_data = 8'h00; c_out_ready = 1'b0; c_flush = 1'b0;
    tick();
    tick();
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
    #1;

    // Reset state
    chk("rst_out_valid", 64'(a_out_valid), 64'h0);
    chk("rst_in_ready",  64'(a_in_ready),  64'h1);
    chk("rst_out_data",  64'(a_out_data),  64'h0);
    chk("rst_count",     64'(a_count),     64'h0);
    chk("rst_stall",     64'(a_stall),     64'h0);
    chk("rst_b_count",   64'(b_count),     64'h0);

    // 1. Fill DEPTH=2 with out_ready=0, then stall three cycles
    a_in_valid = 1'b1; a_in_data = 8'h11;
    tick();
    chk("t1_count1",    64'(a_count),     64'h1);
    chk("t1_latency",   64'(a_out_data),  64'h11);
    a_in_data = 8'h22;
    tick();
    chk("t1_count2",    64'(a_count),     64'h2);
    chk("t1_full_rdy",  64'(a_in_ready),  64'h0);
    chk("t1_head",      64'(a_out_data),  64'h11);
    chk("t1_stall0",    64'(a_stall),     64'h0);
    a_in_data = 8'h33;
    tick(); tick(); tick();
    chk("t1_stall3",    64'(a_stall),     64'h3);
    chk("t1_hold_data", 64'(a_out_data),  64'h11);
    chk("t1_hold_cnt",  64'(a_count),     64'h2);

    // 2. Full with out_ready=1: pop only, then push accepted next cycle
    a_out_ready = 1'b1; a_in_data = 8'h44;
    #1;
    chk("t2_no_refill", 64'(a_in_ready),  64'h0);
    tick();
    chk("t2_count1",    64'(a_count),     64'h1);
    chk("t2_head",      64'(a_out_data),  64'h22);
    chk("t2_stall4",    64'(a_stall),     64'h4);
    chk("t2_rdy",       64'(a_in_ready),  64'h1);
    tick();
    chk("t2_pushpop",   64'(a_count),     64'h1);
    chk("t2_new_head",  64'(a_out_data),  64'h44);
    chk("t2_stall_kept",64'(a_stall),     64'h4);
    a_in_valid = 1'b0;
    tick();
    chk("t2_empty",     64'(a_out_valid), 64'h0);
    chk("t2_empty_data",64'(a_out_data),  64'h0);

    // 4. Flush at count=2 with input offered and out_ready=1
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h55;
    tick();
    a_in_data = 8'h66;
    tick();
    chk("t4_count2",    64'(a_count),     64'h2);
    a_flush = 1'b1; a_out_ready = 1'b1; a_in_data = 8'h99;
    #1;
    chk("t4_fl_rdy",    64'(a_in_ready),  64'h0);
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    #1;
    chk("t4_fl_count",  64'(a_count),     64'h0);
    chk("t4_fl_valid",  64'(a_out_valid), 64'h0);
    chk("t4_fl_stall",  64'(a_stall),     64'h5);
    tick();
    chk("t4_no_99",     64'(a_out_valid), 64'h0);
    a_in_valid = 1'b1; a_in_data = 8'h77;
    tick();
    chk("t4_post_push", 64'(a_out_data),  64'h77);
    // Flush with room left still refuses input
    a_flush = 1'b1; a_in_data = 8'hAA;
    #1;
    chk("t4_fl1_rdy",   64'(a_in_ready),  64'h0);
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    #1;
    chk("t4_fl1_count", 64'(a_count),     64'h0);
    chk("t4_fl1_stall", 64'(a_stall),     64'h6);
    a_in_valid = 1'b1; a_in_data = 8'h5A;
    tick();
    a_in_valid = 1'b0;
    #1;
    chk("t4_restart",   64'(a_out_data),  64'h5A);

    // 3. DEPTH=3 streaming 1..8 with consumer always ready
    b_out_ready = 1'b1; b_in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      b_in_data = 8'(i);
      tick();
      chk("t3_stream",    64'(b_out_data), 64'(i));
      chk("t3_count",     64'(b_count),    64'h1);
    end
    b_in_valid = 1'b0;
    tick();
    chk("t3_drained",   64'(b_out_valid), 64'h0);
    // Fill all three entries, then drain in order
    b_out_ready = 1'b0; b_in_valid = 1'b1;
    b_in_data = 8'hA9; tick();
    b_in_data = 8'hAA; tick();
    b_in_data = 8'hAB; tick();
    b_in_valid = 1'b0;
    #1;
    chk("t3_full_cnt",  64'(b_count),     64'h3);
    chk("t3_full_rdy",  64'(b_in_ready),  64'h0);
    b_out_ready = 1'b1;
    chk("t3_drain0",    64'(b_out_data),  64'hA9);
    tick();
    chk("t3_drain1",    64'(b_out_data),  64'hAA);
    tick();
    chk("t3_drain2",    64'(b_out_data),  64'hAB);
    tick();
    chk("t3_drain_end", 64'(b_count),     64'h0);
    chk("t3_b_stall",   64'(b_stall),     64'h0);

    // 5. Saturating 3-bit stall counter
    c_in_valid = 1'b1; c_in_data = 8'h01;
    tick();
    c_in_data = 8'h02;
    tick();
    chk("t5_full",      64'(c_count),     64'h2);
    for (int i = 0; i < 7; i++) tick();
    chk("t5_stall7",    64'(c_stall),     64'h7);
    for (int i = 0; i < 3; i++) tick();
    chk("t5_sat",       64'(c_stall),     64'h7);
    c_reset = 1'b1;
    tick();
    c_reset = 1'b0; c_in_valid = 1'b0;
    #1;
    chk("t5_rst_stall", 64'(c_stall),     64'h0);
    chk("t5_rst_count", 64'(c_count),     64'h0);

    // 6. Reset while full with push and pop requested
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h12;
    tick();
    a_in_data = 8'h34;
    tick();
    chk("t6_pre_count", 64'(a_count),     64'h2);
    a_out_ready = 1'b1; a_in_data = 8'h56; a_reset = 1'b1;
    tick();
    a_reset = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    #1;
    chk("t6_count",     64'(a_count),     64'h0);
    chk("t6_out_valid", 64'(a_out_valid), 64'h0);
    chk("t6_in_ready",  64'(a_in_ready),  64'h1);
    chk("t6_out_data",  64'(a_out_data),  64'h0);
    chk("t6_stall",     64'(a_stall),     64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_elastic_buf.md
Name: pipe_elastic_buf

Overview:
Parametrised elastic buffer between two pipeline stages, for example fetch→decode and decode→execute. It replaces a plain stage register that has only a valid bit with a DEPTH-entry in-order queue.
- Both sides use a valid/ready handshake.
- It supports a whole-buffer flush for branch/redirect squash.
- It has a saturating back-pressure (stall) counter for performance bring-up.
- The payload is an opaque WIDTH-bit vector; any packed stage struct (fetch/decode/execute/memory data) is cast onto it.

Parameters:
- WIDTH, 128, payload bits per entry (≥1).
- DEPTH, 2, number of entries (1..16; need not be a power of two).
- CNT_W, 32, width of the stall counter (≥1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  buffer accepts the offer this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream consumes the head this cycle.
- out_data  out  WIDTH  head payload.
- flush  in  1  discard all entries and any input this cycle.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- stall_cnt  out  CNT_W  cycles with in_valid=1 and in_ready=0, saturating.

Behaviour:
- Storage: DEPTH×WIDTH array, rd_ptr and wr_ptr (0..DEPTH-1), and an occupancy count.
  - A pointer increments modulo DEPTH: DEPTH-1 → 0.
- Reset: count=0, pointers=0, stall_cnt=0.
  - Outputs after reset: out_valid=0, in_ready=1, out_data=0, count=0.
  - The array contents are not reset.
- Combinational outputs:
  - in_ready = (count != DEPTH) && !flush.
  - out_valid = (count != 0).
  - out_data = array[rd_ptr] when out_valid, else all-zero.
- Push: occurs when in_valid && in_ready.
  - Writes array[wr_ptr] and advances wr_ptr.
- Pop: occurs when out_valid && out_ready && !flush.
  - Advances rd_ptr.
- Count update:
  - push only → count+1.
  - pop only → count-1.
  - push and pop together → unchanged.
  - neither → unchanged.
- Latency: one cycle minimum. Data pushed at edge N is first visible on out_data after edge N. There is no combinational in→out bypass.
- Full: in_ready=0 even if out_ready=1 in the same cycle. There is no same-cycle refill when full, so in_ready does not depend on out_ready (no combinational path).
- Empty: out_valid=0. out_ready is ignored.
- Flush (priority over push/pop):
  - At the next edge, count=0 and rd_ptr=wr_ptr=0.
  - Input offered in the flush cycle is dropped (in_ready=0 that cycle).
  - The head shown during a flush cycle does not count as consumed, even with out_ready=1.
  - Downstream must ignore out_valid in a flush cycle.
  - stall_cnt is not cleared by flush.
- stall_cnt:
  - Increments by 1 at each edge where in_valid=1 and in_ready=0, including flush cycles and full cycles.
  - Saturates at 2^CNT_W-1; it never wraps.
  - Cleared only by reset.
- Reset mid-operation: reset has priority over flush, push and pop. All state returns to its reset values at that edge.
- Data hold: while out_valid=1 and out_ready=0, out_data and count are stable (absent push).
  - Ordering is strictly FIFO.
- Upstream may drop or change in_data while in_ready=0. Only handshaken data is stored.
- DEPTH=1 degenerates to a half-throughput register: accepts at most one entry every 2 cycles when the consumer is always ready.

Test Plan:
1. DEPTH=2, out_ready=0; push A=0x11 then B=0x22 → count=2, in_ready=0, out_data=0x11. Hold in_valid 3 cycles → stall_cnt=3.
2. Full (DEPTH=2) with in_valid=1 and out_ready=1 in the same cycle → pop only; count 2→1. Next cycle, push accepted.
3. DEPTH=3, continuous push 0x1..0x8 with out_ready=1 → output sequence exactly 0x1..0x8, one per cycle after the first-cycle latency. Pointers wrap 2→0 without loss.
4. count=2 and flush=1 with in_valid=1 (data 0x99) and out_ready=1 → next cycle count=0, out_valid=0, 0x99 never appears, stall_cnt +1.
5. CNT_W=3, in_valid=1 held against a full buffer for 10 cycles → stall_cnt reaches 7 and stays 7. Reset → stall_cnt=0.
6. Reset asserted while count=2 and push+pop are active → next cycle count=0, out_valid=0, in_ready=1, out_data=0.
